// File: rtl/starsoc_pkg.sv
// Shared constants and types for the vblank update scheduler.
package starsoc_pkg;

    localparam int DEF_V_VISIBLE = 480;
    localparam int TMR_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: lowest set pending bit at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [PW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] winner
);
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] pick;

    // rotate so rr_ptr lands on bit 0, pick lowest, rotate back
    always_comb begin
        rot  = N_REQ'({pending, pending} >> rr_ptr);
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
        winner = N_REQ'(({pick, pick} << rr_ptr) >> N_REQ);
    end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants game-logic requesters one at a time during vertical blanking.
//   state    | meaning
//   ST_IDLE  | visible area, waiting for vblank start
//   ST_ARB   | picking next pending requester (or finishing the frame)
//   ST_GRANT | one requester owns the update slot
module vblank_update_scheduler
    import starsoc_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int TIMEOUT   = 4096,
    parameter int V_VISIBLE = DEF_V_VISIBLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_tick,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic             clr_err,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             frame_tick,
    output logic             overrun,
    output logic [N_REQ-1:0] timeout_err
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           state;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] pending_left;
    logic [N_REQ-1:0] winner;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    owner_inc;
    logic [TMR_W-1:0] tmr;
    logic             vb_start;
    logic             vb_end;
    logic             done_hit;
    logic             tmo_hit;
    logic             retire;
    logic             ovr_set;

    assign vb_start = pix_tick && (x == 10'd0) && (y == 10'(V_VISIBLE));
    assign vb_end   = pix_tick && (x == 10'd0) && (y == 10'd0);

    always_comb begin
        owner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) owner = PW'(i);
        end
    end

    assign owner_inc = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);

    // done beats a coincident timeout; either one retires the owner
    assign done_hit     = (state == ST_GRANT) && (|(done & grant));
    assign tmo_hit      = (state == ST_GRANT) && !done_hit && (tmr == TMR_W'(TIMEOUT - 1));
    assign retire       = done_hit || tmo_hit;
    assign pending_left = retire ? (pending & ~grant) : pending;
    assign ovr_set      = (state != ST_IDLE) && vb_end && (|pending_left);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_arbiter (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .winner  (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            pending    <= '0;
            rr_ptr     <= '0;
            tmr        <= '0;
            busy       <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (retire) rr_ptr <= owner_inc;
            case (state)
                ST_IDLE: begin
                    if (vb_start) begin
                        pending    <= req;
                        frame_tick <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_ARB;
                    end
                end
                ST_ARB, ST_GRANT: begin
                    if (vb_end) begin
                        grant   <= '0;
                        pending <= '0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (state == ST_ARB) begin
                        if (pending == '0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            grant <= winner;
                            tmr   <= '0;
                            state <= ST_GRANT;
                        end
                    end else if (retire) begin
                        grant   <= '0;
                        pending <= pending_left;
                        state   <= ST_ARB;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // sticky flags: a set in the same cycle as clr_err survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun     <= 1'b0;
            timeout_err <= '0;
        end else begin
            overrun     <= ovr_set | (overrun & ~clr_err);
            timeout_err <= (tmo_hit ? grant : '0) | (timeout_err & {N_REQ{~clr_err}});
        end
    end

endmodule

// File: doc/vblank_update_scheduler.md
VBLANK_UPDATE_SCHEDULER -- requirements
Module: vblank_update_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of game-logic requesters.
REQ-002 The block SHALL have parameter TIMEOUT, default 4096, meaning the maximum clk cycles one grant may be held.
REQ-003 The block SHALL have parameter V_VISIBLE, default 480, meaning the first non-visible line.
REQ-004 clk  input  1  system clock; reset reset, asynchronous, active-high; clock clk.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 pix_tick  input  1  one-clk pixel-enable strobe, aligned to the pixel counter advance.
REQ-007 x  input  10  current horizontal pixel count.
REQ-008 y  input  10  current vertical line count.
REQ-009 req  input  N_REQ  per-requester level request for an update slot this frame.
REQ-010 done  input  N_REQ  per-requester one-clk completion pulse; valid only for the granted requester.
REQ-011 clr_err  input  1  one-clk pulse clearing sticky error flags.
REQ-012 grant  output  N_REQ  one-hot or zero grant, registered.
REQ-013 busy  output  1  high from vblank start until the frame's update sequence ends.
REQ-014 frame_tick  output  1  one-clk pulse at vblank start.
REQ-015 overrun  output  1  sticky: pending work remained when visible area resumed.
REQ-016 timeout_err  output  N_REQ  sticky per-requester grant timeout flags.

Function
REQ-017 vblank_start SHALL be pix_tick && x==0 && y==V_VISIBLE; vblank_end SHALL be pix_tick && x==0 && y==0.
REQ-018 FSM states SHALL be IDLE, ARB, GRANT.
REQ-019 IDLE: on vblank_start, latch pending=req, pulse frame_tick the next cycle, and go to ARB; all other req activity is ignored.
REQ-020 ARB: if pending==0, go to IDLE with busy low the next cycle; otherwise select the lowest-index set pending bit at or above rr_ptr (with wrap), register grant one-hot, clear the timeout counter, and go to GRANT.
REQ-021 Latency: vblank_start sampled in cycle T SHALL give grant high in cycle T+2.
REQ-022 GRANT: done[owner] sampled in cycle D SHALL drop grant in D+1, clear pending[owner], set rr_ptr=(owner+1) mod N_REQ, and return to ARB; the next grant SHALL appear in D+2.
REQ-023 Done bits for non-granted requesters SHALL be ignored.
REQ-024 In GRANT, the timeout counter SHALL increment each clk; at TIMEOUT-1 without done, the block SHALL set timeout_err[owner], clear pending[owner], advance rr_ptr, and go to ARB.
REQ-025 done and timeout in the same cycle: done SHALL win, with no error set.
REQ-026 vblank_end while in ARB or GRANT: the block SHALL apply any same-cycle done first; if pending remains nonzero, it SHALL set overrun. It SHALL then drop grant, clear pending, and go to IDLE.
REQ-027 vblank_start while not in IDLE SHALL be ignored.
REQ-028 rr_ptr SHALL persist across frames so first priority rotates fairly.
REQ-029 clr_err SHALL clear overrun and timeout_err; a set event in the same cycle SHALL win.
REQ-030 busy SHALL equal (state != IDLE), registered.

Reset
REQ-031 Reset SHALL force: state=IDLE, grant=0, pending=0, rr_ptr=0, timeout counter=0, busy=0, frame_tick=0, overrun=0, timeout_err=0.
REQ-032 Reset asserted mid-grant SHALL drop grant asynchronously; no done SHALL be required afterwards.

Structure
REQ-033 V_VISIBLE, the FSM state enum, and the timeout counter width SHALL be defined in shared package starsoc_pkg.
REQ-034 The round-robin pick SHALL be a combinational sub-module rr_arbiter (inputs pending and rr_ptr; output one-hot winner).

Verification
REQ-035 req=4'b1011, rr_ptr=0, done returned 3 cycles after each grant -> grants 0001, 0010, 1000 in order; then busy=0, overrun=0.
REQ-036 Next frame with req=4'b1011 -> first grant is 0001, ordered from rr_ptr=(3+1) mod 4=0; advance a frame with a single requester 1 first and check the first grant becomes 0100/1000 per rr_ptr.
REQ-037 Requester 2 never asserts done, TIMEOUT=16 -> grant drops 16 cycles after assert, timeout_err=4'b0100, next requester granted 2 cycles later.
REQ-038 Done held off until vblank_end with pending=4'b1100 -> overrun=1, grant=0, state IDLE; clr_err -> overrun=0.
REQ-039 Done and timeout coincide -> timeout_err stays 0; reset asserted mid-GRANT -> grant=0 immediately, and the next vblank_start restarts cleanly with grant at T+2.
